relu_cpu_driver: RTL
====================

RELU_CPU_DRIVER -- requirements
Module: relu_cpu_driver

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NRows, 8, matrix rows
- NCols, 8, matrix columns
- Data_W, 32, element width (FP32)
- TIMEOUT, 1024, maximum wait cycles for eng_done or eng_y_rvalid
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmd_go  in  1  start one job; pulse
- cmd_busy  out  1  job in progress
- cmd_done  out  1  one-cycle pulse, job completed
- cmd_err  out  1  one-cycle pulse, job aborted on timeout
- in_valid  in  1  input element valid
- in_ready  out  1  driver accepts input element
- in_data  in  Data_W  input element, row-major order
- eng_x_we  out  1  engine write strobe
- eng_x_row, eng_x_col  out  32 each  engine write address
- eng_x_wdata  out  Data_W  engine write data
- eng_start  out  1  engine start pulse
- eng_busy  in  1  engine busy (status only)
- eng_done  in  1  engine done pulse
- eng_y_re  out  1  engine read strobe
- eng_y_row, eng_y_col  out  32 each  engine read address
- eng_y_rdata  in  Data_W  engine read data
- eng_y_rvalid  in  1  engine read data valid
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts result
- out_data  out  Data_W  result element
- out_last  out  1  high with the final result element

Function
REQ-003 The block SHALL implement FSM states IDLE, LOAD, START, WAIT, RD_REQ, RD_WAIT, OUT, FIN, ERR.
REQ-004 Addressing: row/col counters SHALL start at 0 per phase; col increments first; at col==NCols-1 col wraps to 0 and row increments; last element is (NRows-1, NCols-1).
REQ-005 IDLE: in_ready=0, cmd_busy=0; cmd_go=1 -> LOAD, counters cleared; cmd_go SHALL be ignored in every other state.
REQ-006 cmd_busy SHALL be 1 in all states except IDLE.
REQ-007 LOAD: in_ready=1; on in_valid&&in_ready, eng_x_we=1 in that same cycle (combinational), eng_x_row/col=counters, eng_x_wdata=in_data; the counter then advances; the handshake on the last element -> START.
REQ-008 eng_x_we SHALL be 0 outside LOAD handshake cycles; in_valid without handshake causes no write.
REQ-009 START: eng_start=1 for exactly one cycle; -> WAIT with timeout counter cleared.
REQ-010 WAIT: eng_done=1 -> RD_REQ with counters cleared; otherwise timer increments; timer reaching TIMEOUT-1 with eng_done=0 -> ERR.
REQ-011 eng_done in any state other than WAIT SHALL be ignored.
REQ-012 RD_REQ: eng_y_re=1 for exactly one cycle with eng_y_row/col=counters; -> RD_WAIT, timer cleared; at most one read outstanding.
REQ-013 RD_WAIT: eng_y_rvalid=1 -> out_data<=eng_y_rdata, out_valid<=1, -> OUT; rvalid in the same cycle as eng_y_re (RD_REQ) SHALL be ignored; TIMEOUT cycles without rvalid -> ERR.
REQ-014 OUT: out_valid and out_data held stable until out_ready=1; out_last=1 iff counters are at the last element; on handshake, last -> FIN, else counter advances -> RD_REQ.
REQ-015 eng_y_rvalid outside RD_WAIT SHALL be ignored.
REQ-016 FIN: cmd_done=1 for one cycle -> IDLE. ERR: cmd_err=1 for one cycle, out_valid=0 -> IDLE.
REQ-017 Minimum read throughput: one element per 3 cycles with out_ready held high and 1-cycle engine latency.
REQ-018 eng_busy SHALL not affect state transitions.

Reset
REQ-019 While rst_n=0 the FSM SHALL be IDLE, counters and timer 0, and every output 0 (including out_data, eng_x_wdata, all addresses).
REQ-020 Reset asserted mid-job SHALL abort immediately with no cmd_done/cmd_err pulse; after release, the block SHALL wait in IDLE for a new cmd_go.

Verification
REQ-021 NRows=NCols=2, ReLU engine model with 1-cycle done and 1-cycle read latency; cmd_go, inputs 0x3F800000, 0xBF800000, 0x00000000, 0x80000000 -> writes to (0,0),(0,1),(1,0),(1,1); one eng_start; outputs 0x3F800000, 0, 0, 0; out_last on 4th only; cmd_done once.
REQ-022 Same job, out_ready held low 5 cycles on 2nd result -> out_data stable at 0x00000000, no new eng_y_re until handshake.
REQ-023 TIMEOUT=16, engine never asserts eng_done -> cmd_err pulse 16 cycles after eng_start, no eng_y_re, next cmd_go runs a full job.
REQ-024 cmd_go pulsed during LOAD and WAIT -> ignored; spurious eng_done during LOAD -> no state change.
REQ-025 rst_n asserted in RD_WAIT -> all outputs 0 asynchronously, no cmd_done; new job after release completes correctly.
REQ-026 in_valid gapped (1 of every 3 cycles) -> exactly NRows*NCols writes, addresses in order.

Source files
------------

// File: rtl/relu_cpu_driver.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | relu_cpu_driver                                                          |
// | Streams a row-major matrix into a ReLU engine, starts it, and streams    |
// | the results back out with per-phase cycle timeouts.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module relu_cpu_driver #(
  parameter int NRows   = 8,
  parameter int NCols   = 8,
  parameter int Data_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_go,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic              cmd_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [Data_W-1:0] in_data,
  output logic              eng_x_we,
  output logic [31:0]       eng_x_row,
  output logic [31:0]       eng_x_col,
  output logic [Data_W-1:0] eng_x_wdata,
  output logic              eng_start,
  input  logic              eng_busy,
  input  logic              eng_done,
  output logic              eng_y_re,
  output logic [31:0]       eng_y_row,
  output logic [31:0]       eng_y_col,
  input  logic [Data_W-1:0] eng_y_rdata,
  input  logic              eng_y_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Data_W-1:0] out_data,
  output logic              out_last
);

  localparam int          c_TW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0] c_LAST_ROW = 32'(NRows - 1);
  localparam logic [31:0] c_LAST_COL = 32'(NCols - 1);
  localparam logic [c_TW-1:0] c_TO_M1 = c_TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    START   = 4'd2,
    WAIT    = 4'd3,
    RD_REQ  = 4'd4,
    RD_WAIT = 4'd5,
    OUT     = 4'd6,
    FIN     = 4'd7,
    ERR     = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_row;
  logic [31:0]       r_col;
  logic [c_TW-1:0]   r_timer;
  logic [c_TW-1:0]   w_timer_inc;
  logic              r_out_valid;
  logic [Data_W-1:0] r_out_data;

  logic w_last;
  logic w_in_hs;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_capture;

  // Engine busy is informational only; the sequence is driven by done/rvalid.
  logic w_unused_busy;
  assign w_unused_busy = eng_busy;

  assign w_last      = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
  assign w_in_hs     = (r_state == LOAD) && in_valid;
  assign w_timer_inc = r_timer + 1'b1;
  assign w_capture   = (r_state == RD_WAIT) && eng_y_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_go) begin
          w_state_nxt = LOAD;
          w_cnt_clr   = 1'b1;
        end
      end
      LOAD: begin
        if (in_valid) begin
          w_cnt_inc = 1'b1;
          if (w_last) w_state_nxt = START;
        end
      end
      START: begin
        w_state_nxt = WAIT;
        w_tmr_clr   = 1'b1;
      end
      WAIT: begin
        if (eng_done) begin
          w_state_nxt = RD_REQ;
          w_cnt_clr   = 1'b1;
        end else if (w_timer_inc == c_TO_M1) begin
          w_state_nxt = ERR;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      RD_REQ: begin
        w_state_nxt = RD_WAIT;
        w_tmr_clr   = 1'b1;
      end
      RD_WAIT: begin
        if (eng_y_rvalid) begin
          w_state_nxt = OUT;
        end else if (r_timer == c_TO_M1) begin
          w_state_nxt = ERR;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (w_last) begin
            w_state_nxt = FIN;
          end else begin
            w_cnt_inc   = 1'b1;
            w_state_nxt = RD_REQ;
          end
        end
      end
      FIN:     w_state_nxt = IDLE;
      ERR:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Column-fastest walk; wraps back to (0,0) after the final element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= 32'd0;
      r_col <= 32'd0;
    end else if (w_cnt_clr) begin
      r_row <= 32'd0;
      r_col <= 32'd0;
    end else if (w_cnt_inc) begin
      if (r_col == c_LAST_COL) begin
        r_col <= 32'd0;
        r_row <= (r_row == c_LAST_ROW) ? 32'd0 : r_row + 32'd1;
      end else begin
        r_col <= r_col + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_tmr_clr) begin
      r_timer <= '0;
    end else if (w_tmr_inc) begin
      r_timer <= w_timer_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_data  <= eng_y_rdata;
    end else if (((r_state == OUT) && out_ready) || (r_state == ERR)) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cmd_busy    = (r_state != IDLE);
  assign cmd_done    = (r_state == FIN);
  assign cmd_err     = (r_state == ERR);
  assign in_ready    = (r_state == LOAD);
  assign eng_x_we    = w_in_hs;
  assign eng_x_row   = r_row;
  assign eng_x_col   = r_col;
  // Gated so the write bus reads zero whenever no write is happening.
  assign eng_x_wdata = w_in_hs ? in_data : '0;
  assign eng_start   = (r_state == START);
  assign eng_y_re    = (r_state == RD_REQ);
  assign eng_y_row   = r_row;
  assign eng_y_col   = r_col;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = (r_state == OUT) && w_last;

endmodule
`default_nettype wire
